// File: rtl/alu_mc_pkg.sv
// Shared encodings for alu_mc: op modes, func_op bit positions and FSM states.
// Kept parameter-free so every datapath width can import the same definitions.
package alu_mc_pkg;

    localparam logic [2:0] OP_PASS    = 3'd0;
    localparam logic [2:0] OP_LOGIC   = 3'd1;
    localparam logic [2:0] OP_SHIFT   = 3'd2;
    localparam logic [2:0] OP_COMPARE = 3'd3;
    localparam logic [2:0] OP_ADD_SUB = 3'd4;
    localparam logic [2:0] OP_MUL     = 3'd5;
    localparam logic [2:0] OP_DIV     = 3'd6;
    localparam logic [2:0] OP_REM     = 3'd7;

    localparam int FN_SIGNED     = 0;
    localparam int FN_MULH       = 1;
    localparam int FN_SHR        = 1;
    localparam int FN_ARITH      = 0;
    localparam int FN_SUB        = 0;
    localparam int FN_CMP_GT     = 0;
    localparam int FN_CMP_EQ     = 1;
    localparam int FN_CMP_INC_EQ = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic is_iter_op(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/alu_mc_iter_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle, XLEN iterations.
// done_o and the results are combinational during the last iteration; ALU_MC_MULH_EN widens the product.
module alu_mc_iter_muldiv
    import alu_mc_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic            is_div_i,
    input  logic            signed_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] quot_o,
`ifdef ALU_MC_MULH_EN
    output logic [XLEN-1:0] prod_hi_o,
`endif
    output logic [XLEN-1:0] rem_o,
    output logic            div_zero_o
);

`ifdef ALU_MC_MULH_EN
    localparam int ACCW = 2 * XLEN;
`else
    localparam int ACCW = XLEN;
`endif

    logic [SHW:0]      cnt_q, cnt_d;
    logic              is_div_q, neg_q, rneg_q, dz_q;
    logic [XLEN-1:0]   r_q, r_d;
    logic [ACCW-1:0]   acc_q, acc_d;
    logic [ACCW-1:0]   opb_q, opb_d;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     rem_sh, diff;
    logic [ACCW-1:0]   prod;
    logic [XLEN-1:0]   quot;

    assign a_neg = signed_i & a_i[XLEN-1];
    assign b_neg = signed_i & b_i[XLEN-1];
    assign a_mag = a_neg ? -a_i : a_i;
    assign b_mag = b_neg ? -b_i : b_i;

    // r_q is the multiplier (shifting right) or the dividend/quotient (shifting left).
    assign rem_sh = {acc_q[XLEN-1:0], r_q[XLEN-1]};
    assign diff   = rem_sh - {1'b0, opb_q[XLEN-1:0]};

    always_comb begin
        cnt_d = cnt_q;
        r_d   = r_q;
        acc_d = acc_q;
        opb_d = opb_q;
        if (start_i) begin
            cnt_d = (SHW+1)'(XLEN);
            acc_d = '0;
            if (is_div_i) begin
                r_d   = a_mag;
                opb_d = ACCW'(b_mag);
            end else begin
`ifdef ALU_MC_MULH_EN
                r_d   = b_mag;
                opb_d = ACCW'(a_mag);
`else
                r_d   = b_i;
                opb_d = a_i;
`endif
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - (SHW+1)'(1);
            if (is_div_q) begin
                acc_d = '0;
                if (!diff[XLEN]) begin
                    acc_d[XLEN-1:0] = diff[XLEN-1:0];
                    r_d             = {r_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d[XLEN-1:0] = rem_sh[XLEN-1:0];
                    r_d             = {r_q[XLEN-2:0], 1'b0};
                end
            end else begin
                acc_d = acc_q + (r_q[0] ? opb_q : '0);
                opb_d = opb_q << 1;
                r_d   = r_q >> 1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q    <= '0;
            r_q      <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            r_q   <= r_d;
            acc_q <= acc_d;
            opb_q <= opb_d;
            if (start_i) begin
                is_div_q <= is_div_i;
                rneg_q   <= a_neg;
                dz_q     <= is_div_i && (b_i == '0);
`ifdef ALU_MC_MULH_EN
                neg_q    <= a_neg ^ b_neg;
`else
                // Low-half products are sign-agnostic, so only the divider needs correction.
                neg_q    <= is_div_i & (a_neg ^ b_neg);
`endif
            end
        end
    end

    // Sign correction is applied to the values produced by the final iteration.
    always_comb begin
        prod = neg_q ? -acc_d : acc_d;
        if (dz_q)
            quot = '1;
        else
            quot = neg_q ? -r_d : r_d;
    end

    assign done_o     = (cnt_q == (SHW+1)'(1));
    assign quot_o     = is_div_q ? quot : prod[XLEN-1:0];
    assign rem_o      = rneg_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
    assign div_zero_o = dz_q;
`ifdef ALU_MC_MULH_EN
    assign prod_hi_o  = prod[ACCW-1:XLEN];
`endif

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle integer ALU: single-cycle ops latency 1, MUL/DIV/REM latency XLEN; optional MULH via ALU_MC_MULH_EN.
// Valid/ready on both sides; o_ready drops while iterating and while a held result is not taken.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_op_mode,
    input  logic [2:0]      i_func_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_div_zero
);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            dz_q, dz_d;
    logic [2:0]      op_q, op_d;
`ifdef ALU_MC_MULH_EN
    logic            hi_sel_q, hi_sel_d;
    logic [XLEN-1:0] md_prod_hi;
`endif

    logic            accept, md_start, md_done, md_dz;
    logic [XLEN-1:0] md_quot, md_rem, md_sel;
    logic [XLEN-1:0] alu_res;
    logic [SHW-1:0]  shamt;
    logic            lt, gt, eq, cmp;

    assign o_ready    = (state_q == ST_IDLE) || ((state_q == ST_DONE) && i_ready);
    assign o_valid    = (state_q == ST_DONE);
    assign o_result   = result_q;
    assign o_div_zero = dz_q;
    assign accept     = i_valid && o_ready;
    assign md_start   = accept && is_iter_op(i_op_mode);

    assign shamt = i_b[SHW-1:0];
    assign lt    = $signed(i_a) < $signed(i_b);
    assign gt    = $signed(i_a) > $signed(i_b);
    assign eq    = (i_a == i_b);
    assign cmp   = i_func_op[FN_CMP_EQ] ? eq
                 : ((i_func_op[FN_CMP_GT] ? gt : lt) | (i_func_op[FN_CMP_INC_EQ] & eq));

    always_comb begin
        alu_res = '0;
        case (i_op_mode)
            OP_PASS:    alu_res = i_a;
            OP_LOGIC: begin
                case (i_func_op[1:0])
                    2'd1:    alu_res = i_a | i_b;
                    2'd2:    alu_res = i_a ^ i_b;
                    default: alu_res = i_a & i_b;
                endcase
            end
            OP_SHIFT: begin
                if (!i_func_op[FN_SHR])
                    alu_res = i_a << shamt;
                else if (i_func_op[FN_ARITH])
                    alu_res = $signed(i_a) >>> shamt;
                else
                    alu_res = i_a >> shamt;
            end
            OP_COMPARE: alu_res = {{(XLEN-1){1'b0}}, cmp};
            OP_ADD_SUB: alu_res = i_func_op[FN_SUB] ? (i_a - i_b) : (i_a + i_b);
            default:    alu_res = '0;
        endcase
    end

    alu_mc_iter_muldiv #(
        .XLEN (XLEN),
        .SHW  (SHW)
    ) u_iter_muldiv (
        .clk_i      (i_clk),
        .rst_n_i    (i_rst_n),
        .start_i    (md_start),
        .is_div_i   (i_op_mode != OP_MUL),
        .signed_i   (i_func_op[FN_SIGNED]),
        .a_i        (i_a),
        .b_i        (i_b),
        .done_o     (md_done),
        .quot_o     (md_quot),
`ifdef ALU_MC_MULH_EN
        .prod_hi_o  (md_prod_hi),
`endif
        .rem_o      (md_rem),
        .div_zero_o (md_dz)
    );

    always_comb begin
        md_sel = md_quot;
        if (op_q == OP_REM)
            md_sel = md_rem;
`ifdef ALU_MC_MULH_EN
        if ((op_q == OP_MUL) && hi_sel_q)
            md_sel = md_prod_hi;
`endif
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        dz_d     = dz_q;
        op_d     = op_q;
`ifdef ALU_MC_MULH_EN
        hi_sel_d = hi_sel_q;
`endif
        case (state_q)
            ST_IDLE: ;
            ST_BUSY: begin
                if (md_done) begin
                    state_d  = ST_DONE;
                    result_d = md_sel;
                    dz_d     = md_dz;
                end
            end
            ST_DONE: if (i_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // An accept in DONE overrides the return to IDLE, giving back-to-back issue.
        if (accept) begin
            if (is_iter_op(i_op_mode)) begin
                state_d = ST_BUSY;
                op_d    = i_op_mode;
`ifdef ALU_MC_MULH_EN
                hi_sel_d = i_func_op[FN_MULH];
`endif
            end else begin
                state_d  = ST_DONE;
                result_d = alu_res;
                dz_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            dz_q     <= 1'b0;
            op_q     <= OP_PASS;
`ifdef ALU_MC_MULH_EN
            hi_sel_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            dz_q     <= dz_d;
            op_q     <= op_d;
`ifdef ALU_MC_MULH_EN
            hi_sel_q <= hi_sel_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at XLEN=32: single-cycle ops, iterative mul/div, backpressure, reset abort.
module tb_alu_mc;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [2:0]  i_op_mode;
    logic [2:0]  i_func_op;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic        o_div_zero;

    int total = 0;
    int bad   = 0;

    alu_mc #(.XLEN(32)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_op_mode  (i_op_mode),
        .i_func_op  (i_func_op),
        .i_a        (i_a),
        .i_b        (i_b),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_result   (o_result),
        .o_div_zero (o_div_zero)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [2:0] fn,
                         input logic [31:0] a, input logic [31:0] b);
        i_op_mode = op;
        i_func_op = fn;
        i_a       = a;
        i_b       = b;
        i_valid   = 1'b1;
    endtask

    // Issues one iterative op from IDLE, scrambles the inputs after accept, waits for the result, consumes it.
    task automatic run_long(input logic [2:0] op, input logic [2:0] fn,
                            input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] res, output logic dz,
                            output int cyc, output logic rdy_seen);
        drive(op, fn, a, b);
        step();
        i_valid   = 1'b0;
        i_a       = 32'hA5A5_A5A5;
        i_b       = 32'h0;
        i_func_op = 3'b110;
        cyc       = 0;
        rdy_seen  = 1'b0;
        while (o_valid !== 1'b1 && cyc < 200) begin
            if (o_ready !== 1'b0) rdy_seen = 1'b1;
            step();
            cyc++;
        end
        res = o_result;
        dz  = o_div_zero;
        step();
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        #1;
        total++;
        if (o_valid !== 1'b0 || o_result !== 32'h0 || o_div_zero !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: valid=%b result=%h dz=%b required 0/0/0", o_valid, o_result, o_div_zero);
        end
        repeat (3) step();
        i_rst_n = 1'b1;
        step();
        total++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: ready=%b valid=%b required 1/0", o_ready, o_valid);
        end
    endtask

    logic [2:0]  s_op [14] = '{3'd4, 3'd2, 3'd3, 3'd1, 3'd2, 3'd2, 3'd3,
                               3'd3, 3'd3, 3'd3, 3'd4, 3'd0, 3'd1, 3'd1};
    logic [2:0]  s_fn [14] = '{3'd1, 3'd3, 3'd0, 3'd2, 3'd0, 3'd2, 3'd1,
                               3'd4, 3'd0, 3'd2, 3'd0, 3'd0, 3'd3, 3'd1};
    logic [31:0] s_a  [14] = '{32'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'hF0F0_F0F0,
                               32'd1, 32'h8000_0000, 32'd1, 32'd7, 32'd7, 32'd3,
                               32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'hF0F0_F0F0, 32'h0F0F_0000};
    logic [31:0] s_b  [14] = '{32'd7, 32'h0000_0024, 32'd1, 32'hFF00_FF00,
                               32'h0000_0123, 32'd4, 32'hFFFF_FFFF, 32'd7, 32'd7, 32'd4,
                               32'd2, 32'h1234_5678, 32'hFF00_FF00, 32'h0000_00F0};
    logic [31:0] s_exp[14] = '{32'hFFFF_FFFE, 32'hF800_0000, 32'd1, 32'h0FF0_0FF0,
                               32'd8, 32'h0800_0000, 32'd1, 32'd1, 32'd0, 32'd0,
                               32'd1, 32'hDEAD_BEEF, 32'hF000_F000, 32'h0F0F_00F0};

    task automatic test_single();
        i_ready = 1'b1;
        total++;
        if (o_ready !== 1'b1) begin
            bad++;
            $display("FAIL single_idle_ready: got %b required 1", o_ready);
        end
        for (int i = 0; i < 14; i++) begin
            drive(s_op[i], s_fn[i], s_a[i], s_b[i]);
            step();
            total++;
            if (o_valid !== 1'b1 || o_result !== s_exp[i] || o_ready !== 1'b1 || o_div_zero !== 1'b0) begin
                bad++;
                $display("FAIL single_op[%0d]: valid=%b result=%h ready=%b dz=%b required 1/%h/1/0",
                         i, o_valid, o_result, o_ready, o_div_zero, s_exp[i]);
            end
        end
        i_valid = 1'b0;
        step();
        total++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            bad++;
            $display("FAIL single_to_idle: valid=%b ready=%b required 0/1", o_valid, o_ready);
        end
    endtask

    logic [2:0]  l_op [11] = '{3'd5, 3'd5, 3'd6, 3'd7, 3'd6, 3'd6, 3'd7, 3'd6, 3'd7, 3'd7, 3'd5};
    logic [2:0]  l_fn [11] = '{3'd1, 3'd0, 3'd1, 3'd0, 3'd0, 3'd1, 3'd1, 3'd0, 3'd0, 3'd1, 3'd1};
    logic [31:0] l_a  [11] = '{32'hFFFF_FFFD, 32'h0001_0000, 32'h8000_0000, 32'd100,
                               32'd12345, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                               32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] l_b  [11] = '{32'd7, 32'h0001_0001, 32'hFFFF_FFFF, 32'd0,
                               32'd0, 32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] l_exp[11] = '{32'hFFFF_FFEB, 32'h0001_0000, 32'h8000_0000, 32'd100,
                               32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                               32'd0, 32'd1};
    logic        l_dz [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    task automatic test_muldiv();
        logic [31:0] res;
        logic        dz, rdy;
        int          cyc;
        i_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            run_long(l_op[i], l_fn[i], l_a[i], l_b[i], res, dz, cyc, rdy);
            total++;
            if (res !== l_exp[i] || dz !== l_dz[i]) begin
                bad++;
                $display("FAIL muldiv_result[%0d]: result=%h dz=%b required %h/%b", i, res, dz, l_exp[i], l_dz[i]);
            end
            total++;
            if (cyc !== 32) begin
                bad++;
                $display("FAIL muldiv_latency[%0d]: cycles=%0d required 32", i, cyc);
            end
            total++;
            if (rdy !== 1'b0) begin
                bad++;
                $display("FAIL muldiv_busy_ready[%0d]: ready seen high in BUSY, required low", i);
            end
        end
    endtask

    task automatic test_backpressure();
        i_ready = 1'b0;
        drive(3'd4, 3'd0, 32'd1, 32'd2);
        step();
        i_valid = 1'b0;
        i_a     = 32'h1111_1111;
        for (int k = 0; k < 5; k++) begin
            total++;
            if (o_valid !== 1'b1 || o_result !== 32'd3 || o_ready !== 1'b0 || o_div_zero !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold[%0d]: valid=%b result=%h ready=%b required 1/00000003/0", k, o_valid, o_result, o_ready);
            end
            step();
        end
        i_ready = 1'b1;
        drive(3'd4, 3'd1, 32'd10, 32'd3);
        #1;
        total++;
        if (o_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release_ready: got %b required 1", o_ready);
        end
        step();
        total++;
        if (o_valid !== 1'b1 || o_result !== 32'd7) begin
            bad++;
            $display("FAIL bp_back_to_back: valid=%b result=%h required 1/00000007", o_valid, o_result);
        end
        i_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_div();
        logic [31:0] res;
        logic        dz, rdy, seen;
        int          cyc;
        i_ready = 1'b1;
        drive(3'd6, 3'd0, 32'd1000, 32'd3);
        step();
        i_valid = 1'b0;
        repeat (10) step();
        i_rst_n = 1'b0;
        #1;
        total++;
        if (o_valid !== 1'b0 || o_result !== 32'h0) begin
            bad++;
            $display("FAIL rst_mid_outputs: valid=%b result=%h required 0/00000000", o_valid, o_result);
        end
        repeat (2) step();
        i_rst_n = 1'b1;
        step();
        total++;
        if (o_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_ready: got %b required 1", o_ready);
        end
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (o_valid !== 1'b0) seen = 1'b1;
            step();
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_no_result: aborted op emitted o_valid, required none");
        end
        run_long(3'd6, 3'd0, 32'd1000, 32'd3, res, dz, cyc, rdy);
        total++;
        if (res !== 32'd333 || cyc !== 32 || dz !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_next_op: result=%h cycles=%0d dz=%b required 0000014d/32/0", res, cyc, dz);
        end
    endtask

`ifdef ALU_MC_MULH_EN
    task automatic test_mulh();
        logic [31:0] res;
        logic        dz, rdy;
        int          cyc;
        i_ready = 1'b1;
        run_long(3'd5, 3'd3, 32'h8000_0000, 32'd2, res, dz, cyc, rdy);
        total++;
        if (res !== 32'hFFFF_FFFF || cyc !== 32) begin
            bad++;
            $display("FAIL mulh_signed: result=%h cycles=%0d required ffffffff/32", res, cyc);
        end
        run_long(3'd5, 3'd2, 32'h8000_0000, 32'd2, res, dz, cyc, rdy);
        total++;
        if (res !== 32'h0000_0001 || cyc !== 32) begin
            bad++;
            $display("FAIL mulh_unsigned: result=%h cycles=%0d required 00000001/32", res, cyc);
        end
        run_long(3'd5, 3'd1, 32'h8000_0000, 32'd2, res, dz, cyc, rdy);
        total++;
        if (res !== 32'h0000_0000) begin
            bad++;
            $display("FAIL mulh_low_half: result=%h required 00000000", res);
        end
    endtask
`endif

    initial begin
        i_rst_n   = 1'b0;
        i_valid   = 1'b0;
        i_ready   = 1'b1;
        i_op_mode = 3'd0;
        i_func_op = 3'd0;
        i_a       = 32'h0;
        i_b       = 32'h0;
        test_reset();
        test_single();
        test_muldiv();
        test_backpressure();
        test_reset_mid_div();
`ifdef ALU_MC_MULH_EN
        test_mulh();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
